// File: rtl/vga_timing_pkg.sv
// Shared VGA timing definitions: mode tables, the control word carried through the
// alignment pipe, and the counter-width helper.
package vga_timing_pkg;

  typedef struct packed {
    int unsigned h_active;
    int unsigned h_fp;
    int unsigned h_sync;
    int unsigned h_bp;
    int unsigned v_active;
    int unsigned v_fp;
    int unsigned v_sync;
    int unsigned v_bp;
    logic        hs_pol;
    logic        vs_pol;
  } vga_mode_t;

  // 108 MHz pixel clock, the board's default mode.
  localparam vga_mode_t MODE_1280X1024_60 = '{1280, 48, 112, 248, 1024, 1, 3, 38, 1'b1, 1'b1};
  // 40 MHz pixel clock.
  localparam vga_mode_t MODE_800X600_60   = '{800, 40, 128, 88, 600, 1, 4, 23, 1'b1, 1'b1};
  // 25.175 MHz pixel clock.
  localparam vga_mode_t MODE_640X480_60   = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0};

  // Raw per-position flags delayed to line up with the renderer's colour.
  typedef struct packed {
    logic hsync;
    logic vsync;
    logic active;
    logic line0;
    logic frame0;
  } vga_ctrl_t;

  // Width of a counter spanning 0..n-1, never less than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/vga_align_pipe.sv
// Enable-gated shift register that delays the timing flags by DEPTH ticks;
// DEPTH = 0 makes it a plain wire.
module vga_align_pipe #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (DEPTH == 0) begin : g_wire
    logic unused_ports;
    assign unused_ports = ^{clk, rst, en};
    assign q = d;
  end else begin : g_regs
    logic [WIDTH-1:0] stage [DEPTH];

    // NOTE: sequential state uses non-blocking assignments so every stage samples
    // the previous stage's old value on the same edge.
    always_ff @(posedge clk) begin
      if (rst) begin
        // NOTE: this array is reset on purpose -- stale 'active' bits left in it
        // would leak out as a false data-enable after a mid-frame reset.
        for (int i = 0; i < int'(DEPTH); i++) stage[i] <= '0;
      end else if (en) begin
        stage[0] <= d;
        for (int i = 1; i < int'(DEPTH); i++) stage[i] <= stage[i-1];
      end
    end

    assign q = stage[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_core.sv
// Parametrised VGA timing generator: h/v counters, renderer request coordinates,
// and a registered output stage aligned to the renderer's PIPE_LAT-tick latency.
module vga_timing_core
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = MODE_1280X1024_60.h_active,
  parameter int unsigned H_FP     = MODE_1280X1024_60.h_fp,
  parameter int unsigned H_SYNC   = MODE_1280X1024_60.h_sync,
  parameter int unsigned H_BP     = MODE_1280X1024_60.h_bp,
  parameter int unsigned V_ACTIVE = MODE_1280X1024_60.v_active,
  parameter int unsigned V_FP     = MODE_1280X1024_60.v_fp,
  parameter int unsigned V_SYNC   = MODE_1280X1024_60.v_sync,
  parameter int unsigned V_BP     = MODE_1280X1024_60.v_bp,
  parameter logic        HS_POL   = MODE_1280X1024_60.hs_pol,
  parameter logic        VS_POL   = MODE_1280X1024_60.vs_pol,
  parameter int unsigned PIPE_LAT = 2,
  parameter int unsigned COLOR_W  = 4,
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int unsigned CW      = cnt_w(H_TOTAL),
  localparam int unsigned RW      = cnt_w(V_TOTAL)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pix_en,
  output logic [CW-1:0]      x,
  output logic [RW-1:0]      y,
  output logic               req_valid,
  input  logic [COLOR_W-1:0] pix_r,
  input  logic [COLOR_W-1:0] pix_g,
  input  logic [COLOR_W-1:0] pix_b,
  output logic [COLOR_W-1:0] O_red,
  output logic [COLOR_W-1:0] O_green,
  output logic [COLOR_W-1:0] O_blue,
  output logic               hs,
  output logic               vs,
  output logic               de,
  output logic               frame_start,
  output logic               line_start
);

  if (PIPE_LAT > 7 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
      V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_bad_params
    $fatal(1, "vga_timing_core: PIPE_LAT must be 0..7 and every porch/sync width nonzero");
  end

  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
  localparam logic [CW-1:0] HS_BEGIN = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [RW-1:0] V_LAST   = RW'(V_TOTAL - 1);
  localparam logic [RW-1:0] V_ACT    = RW'(V_ACTIVE);
  localparam logic [RW-1:0] VS_BEGIN = RW'(V_ACTIVE + V_FP);
  localparam logic [RW-1:0] VS_END   = RW'(V_ACTIVE + V_FP + V_SYNC);

  logic [CW-1:0] h;
  logic [RW-1:0] v;
  vga_ctrl_t     ctrl_head;
  vga_ctrl_t     ctrl_tail;

  always_ff @(posedge clk) begin
    if (rst) begin
      h <= '0;
      v <= '0;
    end else if (pix_en) begin
      if (h == H_LAST) begin
        h <= '0;
        v <= (v == V_LAST) ? '0 : v + 1'b1;
      end else begin
        h <= h + 1'b1;
      end
    end
  end

  assign x         = h;
  assign y         = v;
  assign req_valid = (h < H_ACT) && (v < V_ACT);

  // NOTE: every field gets a default before the assignments below, so this block
  // can never infer a latch even if a field is later made conditional.
  always_comb begin
    ctrl_head        = '0;
    ctrl_head.hsync  = (h >= HS_BEGIN) && (h < HS_END);
    ctrl_head.vsync  = (v >= VS_BEGIN) && (v < VS_END);
    ctrl_head.active = req_valid;
    ctrl_head.line0  = (h == '0);
    ctrl_head.frame0 = (h == '0) && (v == '0);
  end

  vga_align_pipe #(
    .WIDTH($bits(vga_ctrl_t)),
    .DEPTH(PIPE_LAT)
  ) u_align (
    .clk(clk),
    .rst(rst),
    .en (pix_en),
    .d  (ctrl_head),
    .q  (ctrl_tail)
  );

  // Start pulses clear on every edge; only an enabled tick can raise them.
  always_ff @(posedge clk) begin
    if (rst) begin
      hs          <= ~HS_POL;
      vs          <= ~VS_POL;
      de          <= 1'b0;
      O_red       <= '0;
      O_green     <= '0;
      O_blue      <= '0;
      frame_start <= 1'b0;
      line_start  <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      line_start  <= 1'b0;
      if (pix_en) begin
        hs          <= ctrl_tail.hsync ? HS_POL : ~HS_POL;
        vs          <= ctrl_tail.vsync ? VS_POL : ~VS_POL;
        de          <= ctrl_tail.active;
        O_red       <= ctrl_tail.active ? pix_r : '0;
        O_green     <= ctrl_tail.active ? pix_g : '0;
        O_blue      <= ctrl_tail.active ? pix_b : '0;
        frame_start <= ctrl_tail.frame0;
        line_start  <= ctrl_tail.line0;
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_core.sv
// Directed bench for vga_timing_core: a small 14x7 mode checked every cycle against
// a position-arithmetic model, plus a default-mode instance with negative hsync.
module tb_vga_timing_core;

  localparam int HA = 8, HF = 2, HSY = 2, HB = 2;
  localparam int VA = 4, VF = 1, VSY = 1, VB = 1;
  localparam int L  = 2;
  localparam int HT = HA + HF + HSY + HB;
  localparam int VT = VA + VF + VSY + VB;
  localparam int TOT = HT * VT;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       pix_en = 1'b1;
  logic [3:0] x;
  logic [2:0] y;
  logic       req_valid;
  logic [3:0] pix_r, pix_g, pix_b;
  logic [3:0] o_r, o_g, o_b;
  logic       hs, vs, de, frame_start, line_start;

  logic        rst_d = 1'b1;
  logic [10:0] x_d, y_d;
  logic        req_valid_d, hs_d, vs_d, de_d, fs_d, ls_d;
  logic [3:0]  o_r_d, o_g_d, o_b_d;

  int n_checks = 0;
  int n_err = 0;

  vga_timing_core #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
    .HS_POL(1'b1), .VS_POL(1'b1), .PIPE_LAT(L), .COLOR_W(4)
  ) dut (
    .clk(clk), .rst(rst), .pix_en(pix_en),
    .x(x), .y(y), .req_valid(req_valid),
    .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
    .O_red(o_r), .O_green(o_g), .O_blue(o_b),
    .hs(hs), .vs(vs), .de(de),
    .frame_start(frame_start), .line_start(line_start)
  );

  vga_timing_core #(
    .HS_POL(1'b0)
  ) dut_def (
    .clk(clk), .rst(rst_d), .pix_en(1'b1),
    .x(x_d), .y(y_d), .req_valid(req_valid_d),
    .pix_r(4'h0), .pix_g(4'h0), .pix_b(4'h0),
    .O_red(o_r_d), .O_green(o_g_d), .O_blue(o_b_d),
    .hs(hs_d), .vs(vs_d), .de(de_d),
    .frame_start(fs_d), .line_start(ls_d)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Colour the bench's renderer paints at a visible position.
  function automatic logic [11:0] colour(input int px, input int py);
    logic [3:0] r, g, b;
    r = 4'(px);
    g = 4'(px + 2 * py);
    b = 4'(~px);
    return {r, g, b};
  endfunction

  // Model state: enabled ticks since reset release, and whether the last edge was enabled.
  int k = 0;
  bit last_en = 1'b0;
  bit model_live = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      k <= 0;
      last_en <= 1'b0;
      model_live <= 1'b1;
    end else if (pix_en) begin
      k <= k + 1;
      last_en <= 1'b1;
    end else begin
      last_en <= 1'b0;
    end
  end

  // Renderer: returns the colour of the position requested L enabled ticks ago.
  int rp, rx, ry;
  always_comb begin
    rp = 0; rx = 0; ry = 0;
    {pix_r, pix_g, pix_b} = 12'hFFF;
    if (k >= L) begin
      rp = (k - L) % TOT;
      rx = rp % HT;
      ry = rp / HT;
      if (rx < HA && ry < VA) {pix_r, pix_g, pix_b} = colour(rx, ry);
    end
  end

  // Every-cycle comparison of the small-mode instance against the model.
  always @(negedge clk) begin
    int q, p, px, py;
    bit act;
    logic [11:0] ec;
    if (model_live) begin
      q = k % TOT;
      check("x", 32'(x), 32'(q % HT));
      check("y", 32'(y), 32'(q / HT));
      check("req_valid", 32'(req_valid), 32'((q % HT) < HA && (q / HT) < VA));
      if (k >= L + 1) begin
        p = (k - L - 1) % TOT;
        px = p % HT;
        py = p / HT;
        act = (px < HA) && (py < VA);
        ec = act ? colour(px, py) : 12'h000;
        check("hs", 32'(hs), 32'(px >= HA + HF && px < HA + HF + HSY));
        check("vs", 32'(vs), 32'(py >= VA + VF && py < VA + VF + VSY));
        check("de", 32'(de), 32'(act));
        check("rgb", 32'({o_r, o_g, o_b}), 32'(ec));
        check("frame_start", 32'(frame_start), 32'(last_en && p == 0));
        check("line_start", 32'(line_start), 32'(last_en && px == 0));
      end else begin
        check("hs_idle", 32'(hs), 32'(0));
        check("vs_idle", 32'(vs), 32'(0));
        check("de_idle", 32'(de), 32'(0));
        check("rgb_idle", 32'({o_r, o_g, o_b}), 32'(0));
        check("fs_idle", 32'(frame_start), 32'(0));
        check("ls_idle", 32'(line_start), 32'(0));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_k(input int target);
    int n = 0;
    while (k != target && n < 500) begin
      tick();
      n++;
    end
    if (k != target) check("wait_k_timeout", 32'(k), 32'(target));
  endtask

  int cnt_hs, cnt_vs, cnt_de, cnt_fs, cnt_ls, fs2_idx;
  int f1, f2, l1, l2, run_fs, run_ls, max_fs, max_ls;
  int n, low_cnt, xmax;
  bit found;

  initial begin
    // Reset held three cycles.
    repeat (3) tick();
    @(negedge clk);
    check("rst_hs", 32'(hs), 32'(0));
    check("rst_vs", 32'(vs), 32'(0));
    check("rst_de", 32'(de), 32'(0));
    check("rst_rgb", 32'({o_r, o_g, o_b}), 32'(0));
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("rel_x", 32'(x), 32'(0));
    check("rel_y", 32'(y), 32'(0));
    check("rel_fs", 32'(frame_start), 32'(0));
    repeat (3) tick();
    @(negedge clk);
    check("first_fs", 32'(frame_start), 32'(1));
    check("first_de", 32'(de), 32'(1));

    // Colour alignment and hsync placement on the first line.
    wait_k(8);  @(negedge clk); check("red_at_x5", 32'(o_r), 32'(5));
    wait_k(11); @(negedge clk); check("red_blank", 32'(o_r), 32'(0));
    wait_k(12); @(negedge clk); check("hs_before", 32'(hs), 32'(0));
    wait_k(13); @(negedge clk); check("hs_first", 32'(hs), 32'(1));
    wait_k(14); @(negedge clk); check("hs_second", 32'(hs), 32'(1));
    wait_k(15); @(negedge clk); check("hs_after", 32'(hs), 32'(0));

    // Two full frames from a frame_start.
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      tick();
      @(negedge clk);
      found = frame_start;
    end
    check("fs_found", 32'(found), 32'(1));
    cnt_hs = 0; cnt_vs = 0; cnt_de = 0; cnt_fs = 0; cnt_ls = 0; fs2_idx = -1;
    for (int i = 0; i < 2 * TOT; i++) begin
      cnt_hs += int'(hs);
      cnt_vs += int'(vs);
      cnt_de += int'(de);
      cnt_ls += int'(line_start);
      if (frame_start) begin
        cnt_fs++;
        if (i > 0 && fs2_idx < 0) fs2_idx = i;
      end
      tick();
      @(negedge clk);
    end
    check("hs_ticks_2f", 32'(cnt_hs), 32'(2 * VT * HSY));
    check("vs_ticks_2f", 32'(cnt_vs), 32'(2 * VSY * HT));
    check("de_ticks_2f", 32'(cnt_de), 32'(64));
    check("fs_count_2f", 32'(cnt_fs), 32'(2));
    check("ls_count_2f", 32'(cnt_ls), 32'(14));
    check("frame_period", 32'(fs2_idx), 32'(98));

    // pix_en on every fourth clock.
    f1 = -1; f2 = -1; l1 = -1; l2 = -1;
    run_fs = 0; run_ls = 0; max_fs = 0; max_ls = 0;
    for (int i = 0; i < 8 * TOT + 8; i++) begin
      pix_en = (i % 4 == 0);
      tick();
      @(negedge clk);
      if (frame_start) begin
        run_fs++;
        if (run_fs == 1) begin
          if (f1 < 0) f1 = i; else if (f2 < 0) f2 = i;
        end
      end else run_fs = 0;
      if (line_start) begin
        run_ls++;
        if (run_ls == 1) begin
          if (l1 < 0) l1 = i; else if (l2 < 0) l2 = i;
        end
      end else run_ls = 0;
      if (run_fs > max_fs) max_fs = run_fs;
      if (run_ls > max_ls) max_ls = run_ls;
    end
    pix_en = 1'b1;
    check("thr_frame_period", 32'(f2 - f1), 32'(4 * 98));
    check("thr_line_period", 32'(l2 - l1), 32'(4 * 14));
    check("thr_fs_width", 32'(max_fs), 32'(1));
    check("thr_ls_width", 32'(max_ls), 32'(1));

    // One-cycle reset while requesting (5,2).
    n = 0;
    while ((k % TOT) != 2 * HT + 5 && n < 200) begin
      tick();
      n++;
    end
    check("mid_pos_reached", 32'(k % TOT), 32'(2 * HT + 5));
    @(negedge clk);
    check("mid_pre_x", 32'(x), 32'(5));
    check("mid_pre_de", 32'(de), 32'(1));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("mid_x", 32'(x), 32'(0));
    check("mid_y", 32'(y), 32'(0));
    check("mid_de", 32'(de), 32'(0));
    check("mid_hs", 32'(hs), 32'(0));
    check("mid_rgb", 32'({o_r, o_g, o_b}), 32'(0));
    for (int i = 1; i <= 2; i++) begin
      tick();
      @(negedge clk);
      check("mid_no_stale_de", 32'(de), 32'(0));
    end
    tick();
    @(negedge clk);
    check("mid_de_back", 32'(de), 32'(1));
    check("mid_fs_back", 32'(frame_start), 32'(1));

    // Default 1280x1024 mode with active-low hsync.
    rst_d = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 3000 && !found; i++) begin
      tick();
      @(negedge clk);
      found = ls_d;
    end
    check("def_ls_found", 32'(found), 32'(1));
    check("def_first_fs", 32'(fs_d), 32'(1));
    check("def_hs_idle", 32'(hs_d), 32'(1));
    n = 0; low_cnt = 0; xmax = 0;
    found = 1'b0;
    while (!found && n < 2000) begin
      if (hs_d == 1'b0) low_cnt++;
      if (int'(x_d) > xmax) xmax = int'(x_d);
      tick();
      @(negedge clk);
      n++;
      found = ls_d;
    end
    check("def_line_period", 32'(n), 32'(1688));
    check("def_hs_low", 32'(low_cnt), 32'(112));
    check("def_x_max", 32'(xmax), 32'(1687));
    check("def_req_x", 32'(x_d), 32'(3));
    check("def_req_y", 32'(y_d), 32'(1));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule
